// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types for the UART receive path.
//   rx_ctrl_state_e : receive sequencer states (IDLE, PUSH, ACK, WAIT)
//   rx_entry_t      : one RX FIFO entry, {perr, data[7:0]}
//   RX_DEPTH_DEF    : default RX FIFO depth
package uart_pkg;

  localparam int RX_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    ACK  = 2'd2,
    WAIT = 2'd3
  } rx_ctrl_state_e;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   DEPTH-entry RX FIFO with first-word-fall-through head.
//   Flush has priority over push and pop; a push into a full FIFO is
//   accepted only when a pop frees a slot in the same cycle.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wr_entry_i at the tail
//   wr_entry_i   entry to write
//   pop_i        drop the head (ignored while empty)
//   flush_i      empty the FIFO on the next edge
//   head_o       current head entry (meaningless while empty_o)
//   level_o      entries held, 0..DEPTH
//   full_o       level_o == DEPTH
//   empty_o      level_o == 0
//   push_ok_o    push accepted this cycle
//   pop_ok_o     pop accepted this cycle
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH = RX_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  rx_entry_t wr_entry_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output rx_entry_t head_o,
  output logic [AW:0] level_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      push_ok_o,
  output logic      pop_ok_o
);

  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     level_reg;

  assign full_o  = (level_reg == (AW+1)'(DEPTH));
  assign empty_o = (level_reg == '0);

  // The pop is evaluated first so that a full FIFO can still accept a
  // push in the cycle its head is being read out.
  assign pop_ok_o  = pop_i && !flush_i && !empty_o;
  assign push_ok_o = push_i && !flush_i && (!full_o || pop_ok_o);

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok_o)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok_o, pop_ok_o})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem[wr_ptr_reg] <= wr_entry_i;
  end

  assign head_o  = mem[rd_ptr_reg];
  assign level_o = level_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Sequences the UART receiver: captures each completed frame with its
//   parity status into the RX FIFO, returns the one-cycle host_read_o
//   acknowledge that re-arms the receiver, and reports FIFO status,
//   sticky overrun, level interrupt and (optionally) RX timeout.
// Build option
//   UART_RX_TIMEOUT_EN : when defined, a rx_tick_i counter raises the sticky
//                        timeout_o after TIMEOUT_TICKS idle ticks with data
//                        waiting, and timeout_o is ORed into rx_irq_o.
//                        When undefined, timeout_o is 0 and rx_tick_i unused.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   rx_done_i        frame-complete level from receiver, held until ack
//   rx_data_i        received data byte
//   parity_error_i   parity flag, valid in the first rx_done_i cycle
//   rx_tick_i        16x baud tick (timeout only)
//   host_read_o      one-cycle acknowledge to the receiver
//   pop_i            host read of RX data register
//   flush_i          synchronous FIFO clear
//   irq_thresh_i     level interrupt threshold (0 behaves as 1)
//   overrun_clr_i    clear sticky overrun
//   rd_data_o        FIFO head {23'b0, perr, data}, 0 while empty
//   level_o          entries held
//   empty_o, full_o  FIFO status
//   overrun_o        sticky: frame arrived while FIFO full
//   rx_irq_o         registered level >= threshold (| timeout_o)
//   timeout_o        sticky RX timeout
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int  DEPTH         = RX_DEPTH_DEF,
  parameter int  TIMEOUT_TICKS = 640,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_done_i,
  input  logic [7:0]    rx_data_i,
  input  logic          parity_error_i,
  input  logic          rx_tick_i,
  output logic          host_read_o,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [AW:0]   irq_thresh_i,
  input  logic          overrun_clr_i,
  output logic [31:0]   rd_data_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overrun_o,
  output logic          rx_irq_o,
  output logic          timeout_o
);

  rx_ctrl_state_e state_reg, state_next;
  rx_entry_t      hold_reg, hold_next;
  rx_entry_t      head;
  logic           push_req;
  logic           push_ok;
  logic           pop_ok;
  logic           overrun_reg;
  logic           irq_reg;
  logic [AW:0]    thresh_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Parity is only valid in the first rx_done_i cycle, so the frame is
  // latched on leaving IDLE. WAIT blocks re-capture of a level that the
  // receiver has not yet dropped after the acknowledge.
  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    host_read_o = 1'b0;
    push_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_done_i) begin
          hold_next.perr = parity_error_i;
          hold_next.data = rx_data_i;
          state_next     = PUSH;
        end
      end
      PUSH: begin
        push_req   = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        host_read_o = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        if (!rx_done_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_req),
    .wr_entry_i (hold_reg),
    .pop_i      (pop_i),
    .flush_i    (flush_i),
    .head_o     (head),
    .level_o    (level_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .push_ok_o  (push_ok),
    .pop_ok_o   (pop_ok)
  );

  assign rd_data_o = empty_o ? 32'd0 : {23'd0, head};

  // A rejected push is an overrun unless the flush is what discarded it.
  // A new overrun beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (push_req && !push_ok && !flush_i) begin
      overrun_reg <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_reg <= 1'b0;
    end
  end
  assign overrun_o = overrun_reg;

  // A zero threshold would fire on an empty FIFO; treat it as 1.
  assign thresh_eff = (irq_thresh_i == '0) ? (AW+1)'(1) : irq_thresh_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_reg <= 1'b0;
    else        irq_reg <= (level_o >= thresh_eff);
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] tick_cnt_reg;
  logic          timeout_reg;
  logic          cnt_clr;

  // The counter only measures idle time with data waiting.
  assign cnt_clr = empty_o || push_ok || pop_ok || flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (cnt_clr) begin
        tick_cnt_reg <= '0;
      end else if (rx_tick_i && (tick_cnt_reg != TW'(TIMEOUT_TICKS))) begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end

      if (pop_ok || flush_i) begin
        timeout_reg <= 1'b0;
      end else if (!cnt_clr && rx_tick_i &&
                   (tick_cnt_reg == TW'(TIMEOUT_TICKS - 1))) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_reg;
`else
  logic unused_ok;
  assign unused_ok = ^{rx_tick_i, pop_ok, (TIMEOUT_TICKS > 0)};
  assign timeout_o = 1'b0;
`endif

  assign rx_irq_o = irq_reg | timeout_o;

endmodule
